// File: rtl/dmi_pkg.sv
// Shared DMI types for the core-domain side of the JTAG debug-module-interface crossing.
package dmi_pkg;

  localparam int unsigned DMI_ABITS = 7;
  localparam int unsigned DMI_DW    = 32;

  typedef enum logic [1:0] {
    DmiNop   = 2'd0,
    DmiRead  = 2'd1,
    DmiWrite = 2'd2,
    DmiRsvd  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DmiSuccess = 2'd0,
    DmiFailed  = 2'd2,
    DmiBusy    = 2'd3
  } dmi_resp_e;

  typedef struct packed {
    logic [DMI_ABITS-1:0] addr;
    logic [DMI_DW-1:0]    data;
    dmi_op_e              op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DW-1:0] data;
    dmi_resp_e         resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } dmi_state_e;

endpackage

// File: rtl/dmi_cdc_responder.sv
// Core-domain DMI endpoint: one request at a time onto the debug-module bus, with a bus timeout
// so the JTAG side always gets a response.
module dmi_cdc_responder
  import dmi_pkg::*;
#(
  parameter int unsigned ABITS   = DMI_ABITS,
  parameter int unsigned DW      = DMI_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [DW-1:0]    req_data_i,
  input  logic [1:0]       req_op_i,
  output logic             dm_req_o,
  output logic             dm_we_o,
  output logic [ABITS-1:0] dm_addr_o,
  output logic [DW-1:0]    dm_wdata_o,
  input  logic             dm_gnt_i,
  input  logic             dm_rvalid_i,
  input  logic [DW-1:0]    dm_rdata_i,
  input  logic             dm_err_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [DW-1:0]    resp_data_o,
  output logic [1:0]       resp_op_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  dmi_state_e      state_q, state_d;
  dmi_op_e         op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dm_req_q, dm_req_d;
  logic            dm_we_q, dm_we_d;
  logic [ABITS-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0]   dm_wdata_q, dm_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  dmi_resp_e       resp_op_q, resp_op_d;

  logic [CntW-1:0] cnt_inc;
  logic            timed_out;

  // Counter saturates at TIMEOUT; timeout fires on the cycle it would reach TIMEOUT.
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign timed_out = (cnt_inc == CntMax);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_op_d    = resp_op_q;
    req_ready_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d = dmi_op_e'(req_op_i);
          unique case (dmi_op_e'(req_op_i))
            DmiRead, DmiWrite: begin
              state_d    = StIssue;
              cnt_d      = '0;
              dm_req_d   = 1'b1;
              dm_we_d    = (dmi_op_e'(req_op_i) == DmiWrite);
              dm_addr_d  = req_addr_i;
              dm_wdata_d = req_data_i;
            end
            DmiNop: begin
              state_d      = StResp;
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
              resp_op_d    = DmiSuccess;
            end
            DmiRsvd: begin
              state_d      = StResp;
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
              resp_op_d    = DmiFailed;
            end
          endcase
        end
      end

      StIssue: begin
        cnt_d = cnt_inc;
        if (dm_gnt_i) begin
          dm_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = StWait;
          // Grant and response in one cycle complete the access immediately.
          if (dm_rvalid_i) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_data_d  = (op_q == DmiRead && !dm_err_i) ? dm_rdata_i : '0;
            resp_op_d    = dm_err_i ? DmiFailed : DmiSuccess;
          end
        end else if (timed_out) begin
          dm_req_d     = 1'b0;
          cnt_d        = '0;
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_op_d    = DmiFailed;
        end
      end

      StWait: begin
        cnt_d = cnt_inc;
        if (dm_rvalid_i) begin
          cnt_d        = '0;
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_data_d  = (op_q == DmiRead && !dm_err_i) ? dm_rdata_i : '0;
          resp_op_d    = dm_err_i ? DmiFailed : DmiSuccess;
        end else if (timed_out) begin
          cnt_d        = '0;
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_op_d    = DmiFailed;
        end
      end

      StResp: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= DmiNop;
      cnt_q        <= '0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_op_q    <= DmiSuccess;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_op_q    <= resp_op_d;
    end
  end

  assign dm_req_o     = dm_req_q;
  assign dm_we_o      = dm_we_q;
  assign dm_addr_o    = dm_addr_q;
  assign dm_wdata_o   = dm_wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_op_o    = resp_op_q;

endmodule
